// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: ALU command codes and sequencer FSM states.
package alu_pkg;

    localparam int unsigned DataW = 32;

    typedef enum logic {
        CmdAdd = 1'b0,
        CmdSub = 1'b1
    } alu_cmd_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StResp   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_alu.sv
// 32-bit ripple-carry ADD/SUB ALU with carry, zero and signed-overflow flags.
module alu_sequencer_alu
    import alu_pkg::*;
(
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  alu_cmd_e         cmd_i,
    output logic [DataW-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             overflow_o
);

    logic [DataW-1:0] b_eff;
    logic             cin;
    logic [DataW-1:0] low_sum;
    logic [DataW:0]   full_sum;

    always_comb begin
        cin      = (cmd_i == CmdSub);
        b_eff    = cin ? ~b_i : b_i;
        // Low 31 bits summed separately to expose the carry into bit 31.
        low_sum  = {1'b0, a_i[DataW-2:0]} + {1'b0, b_eff[DataW-2:0]} + {{(DataW-1){1'b0}}, cin};
        full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{DataW{1'b0}}, cin};
        result_o   = full_sum[DataW-1:0];
        carry_o    = full_sum[DataW];
        zero_o     = (full_sum[DataW-1:0] == '0);
        overflow_o = low_sum[DataW-1] ^ full_sum[DataW];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Holds operands on the ALU for SETTLE_CYCLES cycles, then registers the result and
// hands it off over a valid/ready response interface.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DataW-1:0] req_a,
    input  logic [DataW-1:0] req_b,
    input  logic             req_cmd,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DataW-1:0] resp_result,
    output logic             resp_carryout,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES - 1);

    seq_state_e       state_q;
    logic [DataW-1:0] a_q, b_q;
    alu_cmd_e         cmd_q;
    logic [7:0]       cnt_q;
    logic             req_ready_q, resp_valid_q;
    logic [DataW-1:0] result_q;
    logic             carry_q, zero_q, overflow_q;
    logic [CNT_W-1:0] op_count_q;

    logic [DataW-1:0] alu_result;
    logic             alu_carry, alu_zero, alu_overflow;

    alu_sequencer_alu u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .cmd_i      (cmd_q),
        .result_o   (alu_result),
        .carry_o    (alu_carry),
        .zero_o     (alu_zero),
        .overflow_o (alu_overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            cmd_q        <= CmdAdd;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            overflow_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        a_q         <= req_a;
                        b_q         <= req_b;
                        cmd_q       <= alu_cmd_e'(req_cmd);
                        cnt_q       <= SettleInit;
                        req_ready_q <= 1'b0;
                        state_q     <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        result_q     <= alu_result;
                        carry_q      <= alu_carry;
                        zero_q       <= alu_zero;
                        overflow_q   <= alu_overflow;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        op_count_q   <= op_count_q + CNT_W'(1);
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_result   = result_q;
    assign resp_carryout = carry_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = overflow_q;
    assign op_count      = op_count_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: number of clock cycles the operands are held on the ALU before its outputs are sampled; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1: requester presents an operation.
REQ-006 Port req_ready, output, 1: block can accept an operation.
REQ-007 Port req_a, input, 32: operand A.
REQ-008 Port req_b, input, 32: operand B.
REQ-009 Port req_cmd, input, 1: 0 = ADD, 1 = SUB (A minus B).
REQ-010 Port resp_valid, output, 1: response registers hold a completed result.
REQ-011 Port resp_ready, input, 1: consumer accepts the response.
REQ-012 Port resp_result, output, 32: registered ALU result.
REQ-013 Ports resp_carryout, resp_zero and resp_overflow, outputs, 1 each: registered ALU flags.
REQ-014 Port op_count, output, CNT_W: number of responses handed off since reset.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 In IDLE, when req_valid is 1 the block SHALL latch req_a, req_b and req_cmd into operand registers, load the settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-018 The operand registers SHALL drive the ALU continuously, and SHALL change only on an accept.
REQ-019 In SETTLE with counter nonzero, the counter SHALL decrement by 1 each cycle.
REQ-020 In SETTLE with counter zero, the block SHALL capture the ALU result, carryout, zero and overflow into the resp_* registers and enter RESP.
REQ-021 resp_valid SHALL rise exactly SETTLE_CYCLES cycles after the accepting edge.
REQ-022 In RESP, resp_* outputs SHALL hold stable until resp_valid and resp_ready are both 1; on that edge the FSM SHALL return to IDLE and op_count SHALL increment.
REQ-023 op_count SHALL wrap from all-ones to 0.
REQ-024 req_valid asserted while not in IDLE SHALL be ignored: no latch and no state change.
REQ-025 resp_ready asserted outside RESP SHALL have no effect.
REQ-026 The minimum spacing between accepts SHALL be SETTLE_CYCLES+2 cycles: accept, settle, response hand-off, then return to IDLE.
REQ-027 Arithmetic SHALL be 32-bit two's complement, with results mod 2^32.
REQ-028 SUB SHALL compute A + ~B + 1, with carryout = carry out of bit 31 (1 means no borrow).
REQ-029 overflow SHALL equal carry-into-bit-31 XOR carry-out-of-bit-31.
REQ-030 zero SHALL be 1 if and only if the result is 0.

Reset
REQ-031 Reset assertion SHALL immediately force the following, regardless of state, including mid-SETTLE or mid-RESP: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_result = 0, all resp flags = 0, operand registers = 0, settle counter = 0, op_count = 0.
REQ-032 An in-flight operation interrupted by reset SHALL be discarded and never reported.
REQ-033 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-034 The ADD/SUB command encodings and the FSM state encoding SHALL live in a shared package, alu_pkg.
REQ-035 The block SHALL instantiate exactly one sub-module, the existing ALU, with its operands fed from the operand registers and its command fed from the latched req_cmd.
REQ-036 SETTLE_CYCLES SHALL be chosen to cover the ALU's worst-case ripple-carry delay at the target clock period.

Verification
REQ-037 ADD, A=0x00000001, B=0xFFFFFFFF, SETTLE_CYCLES=4 -> resp_valid rises exactly 4 cycles after accept; result=0x00000000, carryout=1, zero=1, overflow=0.
REQ-038 ADD, A=0x7FFFFFFF, B=0x7FFFFFFF -> result=0xFFFFFFFE, carryout=0, zero=0, overflow=1.
REQ-039 SUB, A=0x80000000, B=0x40000001 -> result=0x3FFFFFFF, carryout=1, overflow=1; SUB, A=B=0x404A04E5 -> result=0, carryout=1, zero=1.
REQ-040 resp_ready held 0 for 10 cycles with req_valid held 1 and operands changing -> resp_* stable, req_ready=0, no second accept; release resp_ready -> op_count increments by exactly 1.
REQ-041 Reset asserted during SETTLE -> outputs cleared immediately per REQ-031; no resp_valid follows; next request is accepted normally.
REQ-042 With CNT_W=4, run 17 back-to-back operations with resp_ready=1 -> op_count wraps to 1 and accept spacing equals SETTLE_CYCLES+2.
